// File: rtl/universal_shift_reg_param.sv
// Parametrised universal shift register with counted burst shift/rotate and busy/done handshake.
// Optional USR_PARITY_EN adds a combinational q_parity output (XOR-reduction of q_out).
module universal_shift_reg_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic [2:0]            sel_mux,
  input  logic                  sr,
  input  logic                  sl,
  input  logic                  en,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  shift_cnt,
`ifdef USR_PARITY_EN
  output logic                  q_parity,
`endif
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  so_r,
  output logic                  so_l,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_HOLD = 3'b000, OP_SHR = 3'b001, OP_SHL = 3'b010,
                         OP_LOAD = 3'b011, OP_ROR = 3'b100, OP_ROL = 3'b101,
                         OP_ASR  = 3'b110;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] q, q_nxt;
  logic [2:0]            mode_r, mode_nxt;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_nxt;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

  // One register step; 111 and 000 both fall through to hold.
  function automatic logic [DATA_WIDTH-1:0] step(input logic [2:0] op,
                                                 input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    case (op)
      OP_SHR:  r = {sr, d[DATA_WIDTH-1:1]};
      OP_SHL:  r = {d[DATA_WIDTH-2:0], sl};
      OP_LOAD: r = in;
      OP_ROR:  r = {d[0], d[DATA_WIDTH-1:1]};
      OP_ROL:  r = {d[DATA_WIDTH-2:0], d[DATA_WIDTH-1]};
      OP_ASR:  r = {d[DATA_WIDTH-1], d[DATA_WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    mode_nxt  = mode_r;
    cnt_nxt   = cnt_r;
    case (state)
      IDLE: begin
        if (start && is_shift(sel_mux)) begin
          // Accepting edge only latches the burst; q is untouched.
          mode_nxt  = sel_mux;
          cnt_nxt   = shift_cnt;
          state_nxt = (shift_cnt != '0) ? RUN : DONE;
        end else if (en) begin
          q_nxt = step(sel_mux, q);
        end
      end
      RUN: begin
        q_nxt   = step(mode_r, q);
        cnt_nxt = cnt_r - 1'b1;
        if (cnt_r == CNT_WIDTH'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (clr) begin
      state  <= IDLE;
      q      <= '0;
      mode_r <= OP_HOLD;
      cnt_r  <= '0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      mode_r <= mode_nxt;
      cnt_r  <= cnt_nxt;
    end
  end

  assign q_out = q;
  assign so_r  = q[0];
  assign so_l  = q[DATA_WIDTH-1];
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

`ifdef USR_PARITY_EN
  assign q_parity = ^q;
`endif

endmodule

// File: tb/tb_universal_shift_reg_param.sv
// Scoreboard bench: stimulus pushes hand-computed post-edge expectations, monitor checks on negedge.
module tb_universal_shift_reg_param;

  logic       i_clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] in = '0;
  logic [2:0] sel_mux = '0;
  logic       sr = 1'b0, sl = 1'b0, en = 1'b0, start = 1'b0;
  logic [3:0] shift_cnt = '0;
  logic [7:0] q_out;
  logic       so_r, so_l, busy, done;
`ifdef USR_PARITY_EN
  logic       q_parity;
`endif

  universal_shift_reg_param #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .i_clk(i_clk), .clr(clr), .in(in), .sel_mux(sel_mux), .sr(sr), .sl(sl),
    .en(en), .start(start), .shift_cnt(shift_cnt),
`ifdef USR_PARITY_EN
    .q_parity(q_parity),
`endif
    .q_out(q_out), .so_r(so_r), .so_l(so_l), .busy(busy), .done(done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] q;
    logic       b;
    logic       d;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per clock edge, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, ".q"},    q_out,       e.q);
        chk({e.nm, ".busy"}, 8'(busy),    8'(e.b));
        chk({e.nm, ".done"}, 8'(done),    8'(e.d));
        chk({e.nm, ".so_r"}, 8'(so_r),    8'(e.q[0]));
        chk({e.nm, ".so_l"}, 8'(so_l),    8'(e.q[7]));
`ifdef USR_PARITY_EN
        chk({e.nm, ".par"},  8'(q_parity), 8'(^e.q));
`endif
      end
    end
  end

  task automatic tick(input logic [7:0] q, input logic b, input logic d, input string nm);
    exp_t e;
    @(posedge i_clk);
    e.q = q; e.b = b; e.d = d; e.nm = nm;
    sb.push_back(e);
    #1;
  endtask

  task automatic set(input logic [2:0] s, input logic e, input logic st,
                     input logic [3:0] c, input logic [7:0] d);
    sel_mux = s; en = e; start = st; shift_cnt = c; in = d;
  endtask

  initial begin
    bit drained;
    // Reset from unknown, then from a loaded value
    tick(8'h00, 0, 0, "rst0");
    clr = 0;
    set(3'b011, 1, 0, 0, 8'h5A); tick(8'h5A, 0, 0, "load5a");
    clr = 1;                     tick(8'h00, 0, 0, "rst1");
    clr = 0;
    // Single steps
    set(3'b011, 1, 0, 0, 8'hA5); tick(8'hA5, 0, 0, "loadA5");
    sr = 1; set(3'b001, 1, 0, 0, 8'h00); tick(8'hD2, 0, 0, "shr");
    sl = 0; set(3'b010, 1, 0, 0, 8'h00); tick(8'hA4, 0, 0, "shl");
    set(3'b111, 1, 0, 0, 8'hFF); tick(8'hA4, 0, 0, "rsvd");
    set(3'b011, 0, 0, 0, 8'hFF); tick(8'hA4, 0, 0, "en0");
    // Rotate-left burst of 3
    set(3'b011, 1, 0, 0, 8'h81); tick(8'h81, 0, 0, "load81");
    set(3'b101, 0, 1, 3, 8'h00); tick(8'h81, 1, 0, "rol.acc");
    start = 0;                   tick(8'h03, 1, 0, "rol.s1");
                                 tick(8'h06, 1, 0, "rol.s2");
                                 tick(8'h0C, 0, 1, "rol.s3");
                                 tick(8'h0C, 0, 0, "rol.idle");
    // ASR burst with sel/en changed mid-burst and during DONE
    set(3'b011, 1, 0, 0, 8'h90); tick(8'h90, 0, 0, "load90");
    set(3'b110, 0, 1, 2, 8'h00); tick(8'h90, 1, 0, "asr.acc");
    set(3'b011, 1, 0, 0, 8'hFF); tick(8'hC8, 1, 0, "asr.s1");
                                 tick(8'hE4, 0, 1, "asr.s2");
                                 tick(8'hE4, 0, 0, "asr.doneign");
    en = 0;
    // ROR burst of 10 aborted by clr after the 4th step
    set(3'b100, 0, 1, 10, 8'h00); tick(8'hE4, 1, 0, "ror.acc");
    start = 0;                    tick(8'h72, 1, 0, "ror.s1");
                                  tick(8'h39, 1, 0, "ror.s2");
                                  tick(8'h9C, 1, 0, "ror.s3");
                                  tick(8'h4E, 1, 0, "ror.s4");
    clr = 1;                      tick(8'h00, 0, 0, "ror.clr");
    clr = 0;                      tick(8'h00, 0, 0, "ror.nodone");
    sl = 1; set(3'b010, 0, 1, 1, 8'h00); tick(8'h00, 1, 0, "re.acc");
    start = 0;                    tick(8'h01, 0, 1, "re.s1");
                                  tick(8'h01, 0, 0, "re.idle");
    // Zero-count burst: straight to DONE
    set(3'b001, 0, 1, 0, 8'h00);  tick(8'h01, 0, 1, "cnt0.acc");
    start = 0;                    tick(8'h01, 0, 0, "cnt0.idle");
    // start held through RUN and DONE: no re-trigger
    set(3'b011, 1, 0, 0, 8'hF0);  tick(8'hF0, 0, 0, "loadF0");
    sr = 0; set(3'b001, 0, 1, 2, 8'h00); tick(8'hF0, 1, 0, "hold.acc");
                                  tick(8'h78, 1, 0, "hold.s1");
                                  tick(8'h3C, 0, 1, "hold.s2");
                                  tick(8'h3C, 0, 0, "hold.done");
    start = 0;                    tick(8'h3C, 0, 0, "hold.idle");
    // start with a non-shift select is a plain single step
    set(3'b011, 1, 1, 5, 8'h33);  tick(8'h33, 0, 0, "stload");
    set(3'b011, 0, 0, 0, 8'h00);  tick(8'h33, 0, 0, "stload.after");

    drained = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      if (sb.size() == 0) begin drained = 1; break; end
    end
    if (!drained) begin
      errs++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/universal_shift_reg_param.md
Name: universal_shift_reg_param

Overview:
Parametrised successor to the team's 4-bit universal shift register, used as a general datapath shifter.
- Adds configurable width, rotate modes and arithmetic shift-right.
- Adds a counted "burst" mode: one start request performs N consecutive shift/rotate steps, with busy/done handshake.
- Single-step operation, with the same serial and parallel inputs as the existing register, is kept for the idle state.

Parameters:
DATA_WIDTH, 8, register width in bits (>=2)
CNT_WIDTH, 4, width of burst shift count; max burst length 2**CNT_WIDTH-1

Ports:
i_clk  input  1  clock; all state updates on the rising edge
clr  input  1  reset, synchronous, active-high
in  input  DATA_WIDTH  parallel load data
sel_mux  input  3  operation select (encoding below)
sr  input  1  serial input inserted at the MSB on shift-right
sl  input  1  serial input inserted at the LSB on shift-left
en  input  1  single-step enable (IDLE only)
start  input  1  burst request, sampled in IDLE only
shift_cnt  input  CNT_WIDTH  burst step count, sampled with start
q_out  output  DATA_WIDTH  register contents
so_r  output  1  = q_out[0] (combinational)
so_l  output  1  = q_out[DATA_WIDTH-1] (combinational)
busy  output  1  high while state = RUN
done  output  1  one-cycle pulse, high while state = DONE

Behaviour:
- sel_mux encoding:
  - 000 hold
  - 001 shift right: {sr, q[W-1:1]}
  - 010 shift left: {q[W-2:0], sl}
  - 011 parallel load of in
  - 100 rotate right
  - 101 rotate left
  - 110 arithmetic shift right: {q[W-1], q[W-1:1]}
  - 111 reserved, treated as hold
- "Shift modes" means 001, 010, 100, 101, 110.
- Reset: clr=1 at an edge gives q_out=0, state=IDLE, busy=0, done=0. clr has priority over everything, including mid-burst; no done pulse for an aborted burst.
- FSM states: IDLE, RUN, DONE. Internal registers: mode_r[2:0], cnt_r[CNT_WIDTH-1:0].
- IDLE, start=1 and sel_mux in shift modes:
  - Latch mode_r=sel_mux and cnt_r=shift_cnt.
  - If shift_cnt != 0, go to RUN; if shift_cnt == 0, go to DONE.
  - q_out is unchanged on the accepting edge.
- IDLE, start=1 with a non-shift sel_mux: start is ignored and the cycle behaves as a single step.
- IDLE, start=0: if en=1, apply sel_mux for one step; if en=0, hold.
- RUN:
  - Each edge applies mode_r once and decrements cnt_r.
  - sr/sl are sampled live at each step.
  - When cnt_r==1 at an edge, that edge performs the final step and moves to DONE.
- Latency: start accepted at edge k gives steps at edges k+1..k+N. busy is high for N cycles. done is high for the single cycle after edge k+N, then the FSM returns to IDLE.
- DONE: q_out holds; en, start and sel_mux are ignored.
- start, en and sel_mux are ignored during RUN and DONE. Changing sel_mux mid-burst has no effect.
- Width rules:
  - Rotates wrap bit 0 to/from bit W-1.
  - The arithmetic shift replicates the MSB.
  - There is no overflow flag.

Optional Feature:
USR_PARITY_EN:
- Defined: adds output q_parity (1 bit) = XOR-reduction of q_out, combinational, 0 after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. q_out=0x5A, clr=1 for one edge -> q_out=0x00, busy=0, done=0, so_r=0, so_l=0.
2. sel=011, in=0xA5, en=1 -> q_out=0xA5; then sel=001, sr=1, en=1 -> q_out=0xD2; then sel=010, sl=0 -> q_out=0xA4.
3. q_out=0x81, sel=101, shift_cnt=3, start one cycle -> busy high exactly 3 cycles; intermediate values 0x03, 0x06, 0x0C; done one cycle; final q_out=0x0C.
4. q_out=0x90, sel=110, shift_cnt=2, start -> 0xC8 then 0xE4; done pulse; sel toggled to 011 mid-burst has no effect.
5. Burst sel=100, shift_cnt=10; clr=1 after 4th step -> q_out=0x00 on that edge, busy=0, no done pulse; a later start is accepted normally.
6. Edge cases:
   - start with shift_cnt=0 -> done next cycle, busy never high, q_out unchanged.
   - start held high during RUN -> no re-trigger.
   - start with sel=011 -> single load, no busy.
